// File: rtl/anim_pkg.sv
// Shared animation definitions: action codes, default frame counts, sprite geometry.
// Used by the character controller and by the sprite renderer.
package anim_pkg;

    typedef enum logic [7:0] {
        STAND  = 8'd0,
        ATTACK = 8'd1,
        MOVEL  = 8'd2,
        MOVER  = 8'd3,
        HURT   = 8'd4,
        DEFEND = 8'd5
    } anim_state_t;

    localparam int DEF_TICKS_PER_FRAME = 4;
    localparam int DEF_STAND_FRAMES    = 8;
    localparam int DEF_ATTACK_FRAMES   = 9;
    localparam int DEF_FORWARD_FRAMES  = 5;
    localparam int DEF_BACKWARD_FRAMES = 5;
    localparam int DEF_HURT_FRAMES     = 4;
    localparam int DEF_DEFEND_FRAMES   = 1;

    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 96;

endpackage

// File: rtl/character_anim_ctrl_if.sv
// Request/animation bundle between game logic (master) and the animation controller (slave).
interface character_anim_ctrl_if;
    import anim_pkg::*;

    logic        frame_clk;
    logic        key_l;
    logic        key_r;
    logic        key_attack;
    logic        key_defend;
    logic        hit;
    anim_state_t character1_state;
    logic [7:0]  frame_num;
    logic        move_l;
    logic        move_r;
    logic        anim_done;

    modport master (
        output frame_clk, key_l, key_r, key_attack, key_defend, hit,
        input  character1_state, frame_num, move_l, move_r, anim_done
    );

    modport slave (
        input  frame_clk, key_l, key_r, key_attack, key_defend, hit,
        output character1_state, frame_num, move_l, move_r, anim_done
    );
endinterface

// File: rtl/character_anim_ctrl_frame_tick_div.sv
// Rising-edge detect on frame_clk plus a TICKS_PER_FRAME divider; adv marks the tick that
// ends a frame period, clr restarts the period when the owning FSM changes action.
module frame_tick_div #(
    parameter int TICKS_PER_FRAME = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    input  logic clr,
    output logic tick,
    output logic adv
);
    logic       frame_clk_q, frame_clk_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;

    assign tick = frame_clk & ~frame_clk_q;
    assign adv  = tick && (tick_cnt_q == 8'(TICKS_PER_FRAME - 1));

    always_comb begin
        frame_clk_d = frame_clk;
        tick_cnt_d  = tick_cnt_q;
        if (tick) begin
            if (clr || adv) tick_cnt_d = 8'd0;
            else            tick_cnt_d = tick_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_clk_q <= 1'b0;
            tick_cnt_q  <= 8'd0;
        end else begin
            frame_clk_q <= frame_clk_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end
endmodule

// File: rtl/character_anim_ctrl.sv
// Character animation sequencer: latches requests, picks the action on each frame tick and
// steps the frame index. HURT state and the hit input exist only when ANIM_HURT_EN is defined.
module character_anim_ctrl
    import anim_pkg::*;
#(
    parameter int TICKS_PER_FRAME = DEF_TICKS_PER_FRAME,
    parameter int STAND_FRAMES    = DEF_STAND_FRAMES,
    parameter int ATTACK_FRAMES   = DEF_ATTACK_FRAMES,
    parameter int FORWARD_FRAMES  = DEF_FORWARD_FRAMES,
    parameter int BACKWARD_FRAMES = DEF_BACKWARD_FRAMES,
    parameter int HURT_FRAMES     = DEF_HURT_FRAMES,
    parameter int DEFEND_FRAMES   = DEF_DEFEND_FRAMES
) (
    input  logic                  Clk,
    input  logic                  Reset,
    character_anim_ctrl_if.slave  bus
);
    logic tick, adv, clr;

    frame_tick_div #(.TICKS_PER_FRAME(TICKS_PER_FRAME)) u_tick_div (
        .clk       (Clk),
        .rst       (Reset),
        .frame_clk (bus.frame_clk),
        .clr       (clr),
        .tick      (tick),
        .adv       (adv)
    );

    anim_state_t state_q, state_d, decide;
    logic [7:0]  frame_q, frame_d;
    logic        move_l_q, move_l_d, move_r_q, move_r_d, done_q, done_d;
    logic        atk_pend_q, atk_pend_d, atk_req, one_shot;

    function automatic logic [7:0] last_frame_of(anim_state_t s);
        case (s)
            ATTACK:  return 8'(ATTACK_FRAMES - 1);
            MOVEL:   return 8'(BACKWARD_FRAMES - 1);
            MOVER:   return 8'(FORWARD_FRAMES - 1);
            HURT:    return 8'(HURT_FRAMES - 1);
            DEFEND:  return 8'(DEFEND_FRAMES - 1);
            default: return 8'(STAND_FRAMES - 1);
        endcase
    endfunction

`ifdef ANIM_HURT_EN
    logic hit_pend_q, hit_pend_d, hit_req;
    assign hit_req = hit_pend_q | bus.hit;
`else
    logic unused_hit;
    assign unused_hit = bus.hit;
`endif

    // Same-cycle requests bypass the pending flop so a tick in that cycle sees them.
    assign atk_req  = atk_pend_q | bus.key_attack;
    assign one_shot = (state_q == ATTACK) || (state_q == HURT);

    always_comb begin
        decide     = state_q;
        state_d    = state_q;
        frame_d    = frame_q;
        atk_pend_d = atk_req;
`ifdef ANIM_HURT_EN
        hit_pend_d = hit_req;
`endif
        move_l_d   = 1'b0;
        move_r_d   = 1'b0;
        done_d     = 1'b0;
        clr        = 1'b0;
        if (tick) begin
`ifdef ANIM_HURT_EN
            // Any hit is either taken here or discarded because we are already hurt.
            hit_pend_d = 1'b0;
            if (hit_req && state_q != HURT) decide = HURT;
            else
`endif
            if (one_shot)                    atk_pend_d = 1'b0;
            else if (atk_req) begin
                decide     = ATTACK;
                atk_pend_d = 1'b0;
            end
            else if (bus.key_defend)         decide = DEFEND;
            else if (bus.key_l ^ bus.key_r)  decide = bus.key_l ? MOVEL : MOVER;
            else                             decide = STAND;

            if (decide != state_q) begin
                state_d = decide;
                frame_d = 8'd0;
                clr     = 1'b1;
            end else if (adv) begin
                if (frame_q == last_frame_of(state_q)) begin
                    frame_d = 8'd0;
                    if (one_shot) begin
                        state_d = STAND;
                        done_d  = 1'b1;
                    end
                end else begin
                    frame_d = frame_q + 8'd1;
                end
            end
            move_l_d = (decide == MOVEL);
            move_r_d = (decide == MOVER);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= STAND;
            frame_q    <= 8'd0;
            move_l_q   <= 1'b0;
            move_r_q   <= 1'b0;
            done_q     <= 1'b0;
            atk_pend_q <= 1'b0;
`ifdef ANIM_HURT_EN
            hit_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            move_l_q   <= move_l_d;
            move_r_q   <= move_r_d;
            done_q     <= done_d;
            atk_pend_q <= atk_pend_d;
`ifdef ANIM_HURT_EN
            hit_pend_q <= hit_pend_d;
`endif
        end
    end

    assign bus.character1_state = state_q;
    assign bus.frame_num        = frame_q;
    assign bus.move_l           = move_l_q;
    assign bus.move_r           = move_r_q;
    assign bus.anim_done        = done_q;
endmodule

// File: doc/character_anim_ctrl.md
# character_anim_ctrl

Sequencer that drives the sprite renderer's animation inputs for one character. It turns player requests (move, attack, defend, hit) into a registered action state and frame index, stepped by the ~60 Hz `frame_clk`. Its outputs `character1_state`, `frame_num`, `move_l` and `move_r` feed the sprite ROM address generator and the position logic directly. It sits between the keyboard/game-logic layer and the sprite renderer.

## Interface
Parameters:
- `TICKS_PER_FRAME`, default 4: frame_clk ticks per animation frame; legal range 1..255.
- `STAND_FRAMES`, default 8: frames in the stand loop.
- `ATTACK_FRAMES`, default 9: frames in the attack one-shot.
- `FORWARD_FRAMES`, default 5: frames in the move-right loop.
- `BACKWARD_FRAMES`, default 5: frames in the move-left loop.
- `HURT_FRAMES`, default 4: frames in the hurt one-shot.
- `DEFEND_FRAMES`, default 1: frames in the defend hold.

Ports:
- `Clk` input 1: 50 MHz clock.
- `Reset` input 1: synchronous, active-high.
- `frame_clk` input 1: frame strobe, level signal synchronous to `Clk`.
- `key_l` input 1: move-left request, level.
- `key_r` input 1: move-right request, level.
- `key_attack` input 1: attack request, level or pulse, latched.
- `key_defend` input 1: defend request, level.
- `hit` input 1: damage event, pulse, latched.
- `character1_state` output 8: action code to the renderer.
- `frame_num` output 8: frame index within the current action.
- `move_l` output 1: one-`Clk` pulse per tick while in MOVEL.
- `move_r` output 1: one-`Clk` pulse per tick while in MOVER.
- `anim_done` output 1: one-`Clk` pulse when an ATTACK or HURT one-shot completes.

## Operation
- Action codes: STAND=0, ATTACK=1, MOVEL=2, MOVER=3, HURT=4, DEFEND=5.
- Tick: `tick = frame_clk & ~frame_clk_q`, where `frame_clk_q` is a registered copy of `frame_clk`.
- Pending flags:
  - `atk_pend` sets on any cycle with `key_attack`=1.
  - `hit_pend` sets on any cycle with `hit`=1.
  - Each flag clears when consumed, and on Reset.
- Decisions are evaluated only on tick cycles, in priority order:
  1. `hit_pend` and state≠HURT → HURT.
  2. State is ATTACK or HURT (one-shot in progress) → stay.
  3. `atk_pend` → ATTACK.
  4. `key_defend` → DEFEND.
  5. `key_l` xor `key_r` → MOVEL or MOVER.
  6. Otherwise → STAND.
- `hit_pend` arriving during HURT is discarded when that tick is evaluated; the character is invulnerable while hurt.
- `atk_pend` arriving during ATTACK or HURT is discarded.
- Both `key_l` and `key_r` high → STAND.
- On any state change:
  - `frame_num` ← 0 and the tick divider `tick_cnt` ← 0.
  - The consumed pending flag clears.
- Frame advance happens on a tick with `tick_cnt == TICKS_PER_FRAME-1` and no state change; otherwise `tick_cnt` increments on each tick.
  - Looping states (STAND, MOVEL, MOVER, DEFEND): `frame_num` wraps from N-1 to 0.
  - One-shot states (ATTACK, HURT): at `frame_num == N-1` the next advance goes to STAND, frame 0, and pulses `anim_done`.
- `move_l`/`move_r` pulse on every tick where the state after that tick's decision is MOVEL/MOVER.
- `frame_num` is always less than the frame count of the current state.

## Timing
- All outputs are registered.
- Reset values: `character1_state`=STAND, `frame_num`=0, `move_l`/`move_r`/`anim_done`=0, `tick_cnt`=0, pending flags 0, `frame_clk_q`=0.
- Latency: outputs update on the first `Clk` edge at which `frame_clk` is sampled high after being low.
- Pulses (`move_*`, `anim_done`) last exactly one `Clk` cycle.
- A request and a tick in the same cycle: the request is visible to that tick's decision, via a combinational bypass of the pending flag.
- Reset asserted mid-animation: STAND, frame 0 on the next edge; pending requests are lost.
- An ATTACK one-shot lasts exactly `ATTACK_FRAMES*TICKS_PER_FRAME` ticks unless preempted by a hit.

## Configuration
- `ANIM_HURT_EN` defined:
  - `hit` is honoured.
  - HURT state is reachable.
- `ANIM_HURT_EN` undefined:
  - `hit_pend` is removed and `hit` is ignored.
  - The HURT branch is compiled out.
  - `character1_state` never equals 4.

## Structure
- Shared package `anim_pkg` holds:
  - the action-code enum `anim_state_t` (8-bit),
  - the default frame-count constants,
  - the sprite width/height constants, which the renderer uses as well.
- Sub-module `frame_tick_div`:
  - contains the edge detector plus the `TICKS_PER_FRAME` divider;
  - outputs `tick` and `adv`;
  - takes input `clr` to zero the divider on state change.
- The controller FSM and frame counter live in the top module.

## Test plan
- Reset, then no keys, 40 ticks, `TICKS_PER_FRAME`=4 → state 0; `frame_num` runs 0..7 and wraps to 0 after tick 32.
- `key_r` held for 8 ticks → state 3 after the first tick; 8 `move_r` pulses; `frame_num` reaches 1 at tick 5; `move_l` never asserts.
- 1-cycle `key_attack` pulse between ticks → ATTACK at the next tick; a second pulse mid-attack is ignored; STAND with an `anim_done` pulse after 36 ticks.
- `hit` during frame 3 of ATTACK → HURT, frame 0 at the next tick; another `hit` during HURT is ignored; STAND after 16 ticks. Build without `ANIM_HURT_EN`: the attack completes normally.
- `key_l` and `key_r` both high → STAND with no move pulses. `key_defend` plus `key_r` → DEFEND with `frame_num` held at 0.
- Reset asserted during HURT frame 2 → state 0, frame 0, all pulses 0 on the next edge; a `key_attack` latched before reset is not executed.
